chan_prio_sched: RTL and testbench

- Packet-granular scheduler that shares one cache write datapath between PORTNUM input channels.
- Two service classes: high-class requests always beat low-class requests. Inside each class, channels are served round-robin with an independent pointer per class.
- A grant is held for a whole packet, until the datapath signals end-of-packet.
- Sits between the per-port input buffers and the shared SRAM write mux; drives the mux select and enable directly.

---
 rtl/chan_sched_pkg.sv | 20 ++
 rtl/chan_prio_sched_rr_pick.sv | 38 +++
 rtl/chan_prio_sched.sv | 155 +++++++++++++++
 tb/tb_chan_prio_sched.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/chan_sched_pkg.sv
// +-----------------------------------------------------------------------+
// | chan_sched_pkg : shared types and defaults for the channel scheduler  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package chan_sched_pkg;

    localparam int PORTNUM_DEF       = 16;
    localparam int MAX_GRANT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } sched_st_e;

endpackage

`default_nettype wire

// File: rtl/chan_prio_sched_rr_pick.sv
// +-----------------------------------------------------------------------+
// | rr_pick : rotating priority encoder, first set bit at or above ptr    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module rr_pick
    import chan_sched_pkg::*;
#(
    parameter int N = PORTNUM_DEF,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_found,
    output logic [W-1:0] o_idx
);

    logic [W-1:0] w_cand;

    // Scan from the farthest offset back to the pointer so the nearest hit wins;
    // N is a power of two, so the W-bit add wraps for free.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            w_cand = i_ptr + W'(i);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/chan_prio_sched.sv
// +-----------------------------------------------------------------------+
// | chan_prio_sched : two-class round-robin packet scheduler              |
// | Optional watchdog: define CHAN_SCHED_WATCHDOG_EN                      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module chan_prio_sched
    import chan_sched_pkg::*;
#(
    parameter int PORTNUM       = PORTNUM_DEF,
    parameter int SELW          = $clog2(PORTNUM),
    parameter int MAX_GRANT_CYC = MAX_GRANT_CYC_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [PORTNUM-1:0] i_req,
    input  logic [PORTNUM-1:0] i_hi_pri,
    input  logic               i_end,
    output logic [PORTNUM-1:0] o_grant,
    output logic [SELW-1:0]    o_sel,
    output logic               o_en,
    output logic               o_ready,
    output logic               o_timeout
);

    if (((1 << SELW) != PORTNUM) || (MAX_GRANT_CYC < 2)) begin : g_cfg_check
        $error("chan_prio_sched: PORTNUM must be a power of two and MAX_GRANT_CYC >= 2");
    end

    sched_st_e          r_state;
    logic [PORTNUM-1:0] r_grant;
    logic [SELW-1:0]    r_sel;
    logic               r_en;
    logic               r_ready;
    logic               r_timeout;
    logic               r_cls_hi;
    logic [SELW-1:0]    r_hi_ptr;
    logic [SELW-1:0]    r_lo_ptr;

    logic [PORTNUM-1:0] w_hi_req;
    logic [PORTNUM-1:0] w_lo_req;
    logic               w_hi_found;
    logic               w_lo_found;
    logic [SELW-1:0]    w_hi_idx;
    logic [SELW-1:0]    w_lo_idx;
    logic [SELW-1:0]    w_win_sel;
    logic [PORTNUM-1:0] w_win_grant;
    logic               w_wd_expire;

    assign w_hi_req = i_req & i_hi_pri;
    assign w_lo_req = i_req & ~i_hi_pri;

    rr_pick #(.N(PORTNUM), .W(SELW)) u_pick_hi (
        .i_req   (w_hi_req),
        .i_ptr   (r_hi_ptr),
        .o_found (w_hi_found),
        .o_idx   (w_hi_idx)
    );

    rr_pick #(.N(PORTNUM), .W(SELW)) u_pick_lo (
        .i_req   (w_lo_req),
        .i_ptr   (r_lo_ptr),
        .o_found (w_lo_found),
        .o_idx   (w_lo_idx)
    );

    assign w_win_sel   = w_hi_found ? w_hi_idx : w_lo_idx;
    assign w_win_grant = PORTNUM'(1) << w_win_sel;

`ifdef CHAN_SCHED_WATCHDOG_EN
    localparam int              c_cnt_w   = (MAX_GRANT_CYC > 2) ? $clog2(MAX_GRANT_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_lim = c_cnt_w'(MAX_GRANT_CYC - 1);

    logic [c_cnt_w-1:0] r_wd_cnt;

    // Held at zero outside GRANT, so it reads 0 in the first GRANT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt <= '0;
        end else if (r_state != GRANT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + c_cnt_w'(1);
        end
    end

    assign w_wd_expire = (r_state == GRANT) && (r_wd_cnt == c_cnt_lim);
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_sel     <= '0;
            r_en      <= 1'b0;
            r_ready   <= 1'b0;
            r_timeout <= 1'b0;
            r_cls_hi  <= 1'b0;
            r_hi_ptr  <= '0;
            r_lo_ptr  <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hi_found || w_lo_found) begin
                        r_state  <= GRANT;
                        r_grant  <= w_win_grant;
                        r_sel    <= w_win_sel;
                        r_en     <= 1'b1;
                        r_ready  <= 1'b0;
                        r_cls_hi <= w_hi_found;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                GRANT: begin
                    // A real end on the limit edge wins over the watchdog.
                    if (i_end || w_wd_expire) begin
                        r_state   <= RELEASE;
                        r_grant   <= '0;
                        r_en      <= 1'b0;
                        r_timeout <= ~i_end;
                        if (r_cls_hi) begin
                            r_hi_ptr <= r_sel + SELW'(1);
                        end else begin
                            r_lo_ptr <= r_sel + SELW'(1);
                        end
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_en    <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_sel     = r_sel;
    assign o_en      = r_en;
    assign o_ready   = r_ready;
    assign o_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_chan_prio_sched.sv
// +-----------------------------------------------------------------------+
// | tb_chan_prio_sched : directed vector bench for chan_prio_sched        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_chan_prio_sched;

    localparam int c_max_cyc = 8;
`ifdef CHAN_SCHED_WATCHDOG_EN
    localparam int c_basic_len = 5;
`else
    localparam int c_basic_len = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] hi = '0;
    logic        endp = 1'b0;
    logic [15:0] o_grant;
    logic [3:0]  o_sel;
    logic        o_en;
    logic        o_ready;
    logic        o_timeout;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    chan_prio_sched #(.PORTNUM(16), .MAX_GRANT_CYC(c_max_cyc)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_hi_pri  (hi),
        .i_end     (endp),
        .o_grant   (o_grant),
        .o_sel     (o_sel),
        .o_en      (o_en),
        .o_ready   (o_ready),
        .o_timeout (o_timeout)
    );

    typedef struct {
        logic        rst;
        logic [15:0] req;
        logic [15:0] hi;
        logic        endp;
        int          n;
        logic [15:0] g;
        logic [3:0]  s;
        logic        en;
        logic        rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [15:0] rq, input logic [15:0] h,
                       input logic e, input int n, input logic [15:0] g,
                       input logic [3:0] s, input logic en, input logic rdy);
        vec_t v;
        v.rst = r; v.req = rq; v.hi = h; v.endp = e; v.n = n;
        v.g = g; v.s = s; v.en = en; v.rdy = rdy;
        tbl.push_back(v);
    endtask

    // Select is only meaningful while enabled; grant must match select then.
    task automatic chk(input string nm, input logic [15:0] g, input logic [3:0] s,
                       input logic en, input logic rdy, input logic to);
        logic [15:0] onehot;
        onehot = 16'h0001 << o_sel;
        n_vec++;
        if (o_grant !== g || o_en !== en || o_ready !== rdy || o_timeout !== to ||
            (en && o_sel !== s) || (o_en && o_grant !== onehot)) begin
            n_bad++;
            $display("FAIL %s: got grant=%h sel=%0d en=%b ready=%b timeout=%b, want grant=%h sel=%0d en=%b ready=%b timeout=%b",
                     nm, o_grant, o_sel, o_en, o_ready, o_timeout, g, s, en, rdy, to);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // basic round robin, low class
        add(1, 16'h0000, 16'h0000, 0, 2,             16'h0000, 0, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h0003, 16'h0000, 0, 1,             16'h0001, 0, 1, 0);
        add(0, 16'h0003, 16'h0000, 0, c_basic_len-1, 16'h0001, 0, 1, 0);
        add(0, 16'h0003, 16'h0000, 1, 1,             16'h0000, 0, 0, 0);
        add(0, 16'h0003, 16'h0000, 1, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h0003, 16'h0000, 0, 1,             16'h0002, 1, 1, 0);
        add(0, 16'h0003, 16'h0000, 1, 1,             16'h0000, 0, 0, 0);
        add(0, 16'h0000, 16'h0000, 1, 3,             16'h0000, 0, 0, 1);
        // class priority from fresh pointers
        add(1, 16'h0000, 16'h0000, 0, 1,             16'h0000, 0, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h8001, 16'h8000, 0, 1,             16'h8000, 15, 1, 0);
        add(0, 16'h8001, 16'h0000, 0, 3,             16'h8000, 15, 1, 0);
        add(0, 16'h8001, 16'h0000, 1, 1,             16'h0000, 0, 0, 0);
        add(0, 16'h8001, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h8001, 16'h0000, 0, 1,             16'h0001, 0, 1, 0);
        add(0, 16'h8001, 16'h0000, 1, 1,             16'h0000, 0, 0, 0);
        // wrap: serve 14 so lo_ptr=15, then 15 is idle and 0 wins
        add(0, 16'h4000, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h4000, 16'h0000, 0, 1,             16'h4000, 14, 1, 0);
        add(0, 16'h4000, 16'h0000, 1, 1,             16'h0000, 0, 0, 0);
        add(0, 16'h4001, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h4001, 16'h0000, 0, 1,             16'h0001, 0, 1, 0);
        add(0, 16'h4001, 16'h0000, 1, 1,             16'h0000, 0, 0, 0);
        // request dropped while granted
        add(0, 16'h0008, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h0008, 16'h0000, 0, 1,             16'h0008, 3, 1, 0);
        add(0, 16'h0000, 16'hFFFF, 0, 4,             16'h0008, 3, 1, 0);
        add(0, 16'h0000, 16'h0000, 1, 1,             16'h0000, 0, 0, 0);
        add(0, 16'h0000, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        // move hi_ptr to 6 and lo_ptr stays 4, then grant ch4
        add(0, 16'h0020, 16'h0020, 0, 1,             16'h0020, 5, 1, 0);
        add(0, 16'h0020, 16'h0020, 1, 1,             16'h0000, 0, 0, 0);
        add(0, 16'h0010, 16'h0000, 0, 1,             16'h0000, 0, 0, 1);
        add(0, 16'h0010, 16'h0000, 0, 1,             16'h0010, 4, 1, 0);

        foreach (tbl[k]) begin
            rst_n = ~tbl[k].rst;
            req   = tbl[k].req;
            hi    = tbl[k].hi;
            endp  = tbl[k].endp;
            for (int c = 0; c < tbl[k].n; c++) begin
                tick();
                chk($sformatf("vec%0d.%0d", k, c), tbl[k].g, tbl[k].s, tbl[k].en, tbl[k].rdy, 1'b0);
            end
        end

        // asynchronous reset while ch4 is granted
        #1;
        rst_n = 1'b0;
        #2;
        chk("async_rst", 16'h0000, 0, 0, 0, 0);
        req = '0; hi = '0; endp = 0;
        tick();
        rst_n = 1'b1;
        // hi pointer back at 0: ch0 beats ch6
        req = 16'h0041; hi = 16'h0041;
        tick(); chk("hi_ptr_rst", 16'h0001, 0, 1, 0, 0);
        endp = 1;
        tick(); chk("hi_ptr_rel", 16'h0000, 0, 0, 0, 0);
        endp = 0; req = 16'h0011; hi = 16'h0000;
        tick(); chk("lo_ptr_idle", 16'h0000, 0, 0, 1, 0);
        // lo pointer back at 0: ch0 beats ch4
        tick(); chk("lo_ptr_rst", 16'h0001, 0, 1, 0, 0);
        endp = 1;
        tick(); chk("lo_ptr_rel", 16'h0000, 0, 0, 0, 0);
        endp = 0; req = 16'h0000;

        // fresh state for the long-grant section
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); chk("wd_idle", 16'h0000, 0, 0, 1, 0);
        req = 16'h0003;
`ifdef CHAN_SCHED_WATCHDOG_EN
        for (int c = 0; c < c_max_cyc; c++) begin
            tick(); chk($sformatf("wd_hold%0d", c), 16'h0001, 0, 1, 0, 0);
        end
        tick(); chk("wd_release", 16'h0000, 0, 0, 0, 1);
        tick(); chk("wd_idle2", 16'h0000, 0, 0, 1, 0);
        tick(); chk("wd_next", 16'h0002, 1, 1, 0, 0);
        for (int c = 1; c < c_max_cyc; c++) begin
            tick(); chk($sformatf("wd_hold2_%0d", c), 16'h0002, 1, 1, 0, 0);
        end
        endp = 1;
        tick(); chk("wd_end_on_limit", 16'h0000, 0, 0, 0, 0);
        endp = 0;
        tick(); chk("wd_idle3", 16'h0000, 0, 0, 1, 0);
`else
        for (int c = 0; c < 100; c++) begin
            tick(); chk($sformatf("long_hold%0d", c), 16'h0001, 0, 1, 0, 0);
        end
        endp = 1;
        tick(); chk("long_release", 16'h0000, 0, 0, 0, 0);
        endp = 0;
        tick(); chk("long_idle", 16'h0000, 0, 0, 1, 0);
        tick(); chk("long_next", 16'h0002, 1, 1, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
